// File: rtl/tdc_event_fifo_pkg.sv
// tdc_event_fifo_pkg
//   Shared definitions for the TDC event FIFO: Wishbone register word
//   addresses, STATUS/CTRL bit positions, CTRL reset value and the EV_META
//   packing helper. Imported by tdc_event_fifo and tdc_event_fifo_mem.
package tdc_event_fifo_pkg;

  typedef enum logic [2:0] {
    REG_STATUS  = 3'd0,
    REG_EV_TS   = 3'd1,
    REG_EV_META = 3'd2,
    REG_CTRL    = 3'd3,
    REG_DROPCNT = 3'd4
  } reg_adr_e;

  localparam int STATUS_EMPTY_BIT = 16;
  localparam int STATUS_FULL_BIT  = 17;
  localparam int STATUS_OVF_BIT   = 18;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int CTRL_THR_LSB   = 8;

  localparam logic [31:0] CTRL_RESET = 32'h0000_0100;

  // Channel index field carried with every entry; covers up to 64 channels.
  localparam int CH_IDX_W = 6;

  // EV_META layout: [31] valid, [30] polarity, [29:24] channel, [23:0] ts high bits.
  function automatic logic [31:0] pack_meta(input logic pol, input logic [CH_IDX_W-1:0] ch,
                                            input logic [23:0] ts_hi);
    return {1'b1, pol, ch, ts_hi};
  endfunction

endpackage

// File: rtl/tdc_event_fifo_mem.sv
// tdc_event_fifo_mem
//   Synchronous FIFO on an inferred dual-port RAM (registered write, combinational
//   head read). Pushes while full and pops while empty are ignored; flush empties
//   the FIFO and takes priority over a push in the same cycle.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write one entry
//   pop             discard the head entry
//   flush           empty the FIFO
//   head            entry at the read pointer (stale when empty)
//   level           entry count, DEPTH_LOG2+1 bits
//   full, empty     status flags
module tdc_event_fifo_mem
  import tdc_event_fifo_pkg::*;
#(
  parameter int W          = 45,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [W-1:0]          head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  logic [W-1:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // RAM storage is not reset so it maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/tdc_event_fifo.sv
// tdc_event_fifo
//   Captures per-channel TDC detect events {channel, polarity, timestamp} into a
//   FIFO read by the CPU over Wishbone. Each channel has a one-deep pending
//   register; pendings drain into the FIFO one per cycle, round-robin starting
//   after the last served channel. Level interrupt on a programmable threshold.
//   Optional feature macro: TDC_EVFIFO_DROPCNT_EN adds a 16-bit saturating
//   dropped-event counter at word address 4 (reads 0 when undefined).
// Ports
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   ev_stb_i/ev_pol_i    per-channel detect strobe and edge polarity
//   ev_ts_i              timestamps, channel c at [c*TS_W +: TS_W]
//   wb_*                 Wishbone slave, word addressed, one wait state
//   irq_o                registered level interrupt
module tdc_event_fifo
  import tdc_event_fifo_pkg::*;
#(
  parameter int CH_COUNT   = 2,
  parameter int TS_W       = 38,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [CH_COUNT-1:0]      ev_stb_i,
  input  logic [CH_COUNT-1:0]      ev_pol_i,
  input  logic [CH_COUNT*TS_W-1:0] ev_ts_i,
  input  logic [2:0]               wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  output logic [31:0]              wb_dat_o,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  output logic                     wb_ack_o,
  output logic                     irq_o
);

  localparam int ENTRY_W = 1 + CH_IDX_W + TS_W;
  localparam int LW      = DEPTH_LOG2 + 1;

  logic                               ack_q, ack_d;
  logic [31:0]                        dat_q, dat_d;
  logic                               irq_q, irq_d;
  logic                               enable_q, enable_d;
  logic [7:0]                         thr_q, thr_d;
  logic                               ovf_q, ovf_d;
  logic [CH_IDX_W-1:0]                last_q, last_d;
  logic [CH_COUNT-1:0]                pend_q, pend_d;
  logic [CH_COUNT-1:0]                pol_q, pol_d;
  logic [CH_COUNT-1:0][TS_W-1:0]      ts_q, ts_d;

  logic                               access, wr, rd, pop, flush, ovf_clr;
  logic                               hi_found, lo_found;
  logic [CH_IDX_W-1:0]                hi_idx, lo_idx, sel_idx;
  logic                               push;
  logic [ENTRY_W-1:0]                 push_data;
  logic [CH_COUNT-1:0]                gnt, drop;
  logic [ENTRY_W-1:0]                 head;
  logic [LW-1:0]                      level;
  logic                               full, empty;
  logic [31:0]                        rdata;
  logic                               unused_dat;

  assign unused_dat = ^{wb_dat_i[31:19], wb_dat_i[17:16], wb_dat_i[7:2]};

  // Side effects happen on the edge that raises ack.
  assign access  = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr      = access & wb_we_i;
  assign rd      = access & ~wb_we_i;
  assign flush   = wr & (wb_adr_i == REG_CTRL) & wb_dat_i[CTRL_FLUSH_BIT];
  assign ovf_clr = wr & (wb_adr_i == REG_STATUS) & wb_dat_i[STATUS_OVF_BIT];
  assign pop     = rd & (wb_adr_i == REG_EV_META) & ~empty;

  tdc_event_fifo_mem #(
    .W          (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // Round-robin: lowest pending index above last_q wins, else lowest overall.
  always_comb begin
    hi_found  = 1'b0;
    lo_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    gnt       = '0;
    push_data = '0;
    for (int c = CH_COUNT - 1; c >= 0; c--) begin
      if (pend_q[c]) begin
        if (CH_IDX_W'(c) > last_q) begin
          hi_found = 1'b1;
          hi_idx   = CH_IDX_W'(c);
        end else begin
          lo_found = 1'b1;
          lo_idx   = CH_IDX_W'(c);
        end
      end
    end
    sel_idx = hi_found ? hi_idx : lo_idx;
    push    = (hi_found | lo_found) & ~full & ~flush;
    for (int c = 0; c < CH_COUNT; c++) begin
      if (push && (sel_idx == CH_IDX_W'(c))) begin
        gnt[c]    = 1'b1;
        push_data = {pol_q[c], CH_IDX_W'(c), ts_q[c]};
      end
    end
  end

  // A strobe on a channel whose pending is being drained this cycle reuses the slot.
  always_comb begin
    pend_d = pend_q;
    pol_d  = pol_q;
    ts_d   = ts_q;
    drop   = '0;
    for (int c = 0; c < CH_COUNT; c++) begin
      if (gnt[c]) pend_d[c] = 1'b0;
      if (ev_stb_i[c] && enable_q && !flush) begin
        if (pend_q[c] && !gnt[c]) begin
          drop[c] = 1'b1;
        end else begin
          pend_d[c] = 1'b1;
          pol_d[c]  = ev_pol_i[c];
          ts_d[c]   = ev_ts_i[c*TS_W +: TS_W];
        end
      end
    end
    if (flush) pend_d = '0;
    last_d = push ? sel_idx : last_q;
  end

  // A drop in the same cycle as a clear write wins, so no event goes unreported.
  always_comb begin
    enable_d = enable_q;
    thr_d    = thr_q;
    if (wr && (wb_adr_i == REG_CTRL)) begin
      enable_d = wb_dat_i[CTRL_EN_BIT];
      thr_d    = wb_dat_i[CTRL_THR_LSB +: 8];
    end
    ovf_d = flush ? 1'b0 : ((ovf_q & ~ovf_clr) | (|drop));
    irq_d = enable_q & (thr_q != 8'd0) & (32'(level) >= 32'(thr_q));
    ack_d = access;
  end

`ifdef TDC_EVFIFO_DROPCNT_EN
  logic [15:0] dropcnt_q, dropcnt_d;
  logic [16:0] dropsum;

  always_comb begin
    dropsum = {1'b0, (ovf_clr | flush) ? 16'h0000 : dropcnt_q};
    for (int c = 0; c < CH_COUNT; c++) begin
      dropsum = dropsum + 17'(drop[c]);
    end
    dropcnt_d = dropsum[16] ? 16'hFFFF : dropsum[15:0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) dropcnt_q <= '0;
    else            dropcnt_q <= dropcnt_d;
  end
`endif

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      REG_STATUS: begin
        rdata[LW-1:0]           = level;
        rdata[STATUS_EMPTY_BIT] = empty;
        rdata[STATUS_FULL_BIT]  = full;
        rdata[STATUS_OVF_BIT]   = ovf_q;
      end
      REG_EV_TS: begin
        if (!empty) rdata = head[31:0];
      end
      REG_EV_META: begin
        if (!empty) rdata = pack_meta(head[ENTRY_W-1], head[TS_W +: CH_IDX_W],
                                      24'(head[TS_W-1:32]));
      end
      REG_CTRL: begin
        rdata[CTRL_EN_BIT]          = enable_q;
        rdata[CTRL_THR_LSB +: 8]    = thr_q;
      end
      REG_DROPCNT: begin
`ifdef TDC_EVFIFO_DROPCNT_EN
        rdata = {16'h0000, dropcnt_q};
`else
        rdata = '0;
`endif
      end
      default: rdata = '0;
    endcase
    dat_d = rd ? rdata : 32'h0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
      enable_q <= CTRL_RESET[CTRL_EN_BIT];
      thr_q    <= CTRL_RESET[CTRL_THR_LSB +: 8];
      ovf_q    <= 1'b0;
      last_q   <= CH_IDX_W'(CH_COUNT - 1);
      pend_q   <= '0;
      pol_q    <= '0;
      ts_q     <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
      enable_q <= enable_d;
      thr_q    <= thr_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      pol_q    <= pol_d;
      ts_q     <= ts_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_tdc_event_fifo.sv
`timescale 1ns/1ps
module tb_tdc_event_fifo;

  localparam int DEPTH = 64;
  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_TS     = 3'd1;
  localparam logic [2:0] A_META   = 3'd2;
  localparam logic [2:0] A_CTRL   = 3'd3;
  localparam logic [2:0] A_DROP   = 3'd4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [1:0]  ev_stb_i = '0;
  logic [1:0]  ev_pol_i = '0;
  logic [75:0] ev_ts_i = '0;
  logic [2:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic        wb_ack_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;
  int exp_drop;
  int tb_last = 1;
  logic [44:0] sb_q[$];

  tdc_event_fifo #(.CH_COUNT(2), .TS_W(38), .DEPTH_LOG2(6)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ev_stb_i  (ev_stb_i),
    .ev_pol_i  (ev_pol_i),
    .ev_ts_i   (ev_ts_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_ack_o  (wb_ack_o),
    .irq_o     (irq_o)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] status_exp(input int lvl, input bit ovf);
    logic [31:0] s;
    s = 32'(lvl);
    if (lvl == 0)     s[16] = 1'b1;
    if (lvl == DEPTH) s[17] = 1'b1;
    s[18] = ovf;
    return s;
  endfunction

  function automatic logic [44:0] mk(input int ch, input logic pol, input logic [37:0] ts);
    return {pol, 6'(ch), ts};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wb_xfer(input logic we, input logic [2:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    logic got;
    @(negedge sys_clk);
    wb_adr_i = adr; wb_dat_i = wdat; wb_we_i = we; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge sys_clk); #1;
      got = wb_ack_o;
    end
    rdat = wb_dat_o;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wb_ack_timeout adr=%0d: ack=0 required 1", adr);
    end
    @(negedge sys_clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] adr, output logic [31:0] d);
    wb_xfer(1'b0, adr, 32'h0, d);
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [31:0] d);
    logic [31:0] unused_r;
    wb_xfer(1'b1, adr, d, unused_r);
  endtask

  // Single-cycle strobe; when track is set, predicted FIFO order goes to the scoreboard.
  task automatic ev_pulse(input logic [1:0] mask, input logic [1:0] pol,
                          input logic [37:0] t0, input logic [37:0] t1, input bit track);
    int first;
    @(negedge sys_clk);
    ev_stb_i = mask; ev_pol_i = pol; ev_ts_i = {t1, t0};
    @(negedge sys_clk);
    ev_stb_i = '0;
    if (track) begin
      if (mask == 2'b11) begin
        first = (tb_last == 0) ? 1 : 0;
        if (first == 0) begin
          sb_q.push_back(mk(0, pol[0], t0)); sb_q.push_back(mk(1, pol[1], t1)); tb_last = 1;
        end else begin
          sb_q.push_back(mk(1, pol[1], t1)); sb_q.push_back(mk(0, pol[0], t0)); tb_last = 0;
        end
      end else if (mask[0]) begin
        sb_q.push_back(mk(0, pol[0], t0)); tb_last = 0;
      end else if (mask[1]) begin
        sb_q.push_back(mk(1, pol[1], t1)); tb_last = 1;
      end
    end
  endtask

  task automatic pop_check(input string tag);
    logic [44:0] e;
    logic [31:0] d, m;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty: queue size 0 required >0", tag);
      return;
    end
    e = sb_q.pop_front();
    wb_read(A_TS, d);
    checks++;
    if (d !== e[31:0]) begin
      errors++;
      $display("FAIL %s ev_ts: got %h expected %h", tag, d, e[31:0]);
    end
    m = {1'b1, e[44], e[43:38], 18'h0, e[37:32]};
    wb_read(A_META, d);
    checks++;
    if (d !== m) begin
      errors++;
      $display("FAIL %s ev_meta: got %h expected %h", tag, d, m);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    idle(2);
    sys_rst_n = 1'b1;
    sb_q.delete();
    tb_last = 1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b dat=%h irq=%b expected 0 0 0", wb_ack_o, wb_dat_o, irq_o);
    end
    wb_read(A_STATUS, d);
    checks++;
    if (d !== status_exp(0, 0)) begin errors++; $display("FAIL reset_status: got %h expected %h", d, status_exp(0, 0)); end
    wb_read(A_CTRL, d);
    checks++;
    if (d !== 32'h0000_0100) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000100", d); end
    wb_read(A_DROP, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_dropcnt: got %h expected 0", d); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    wb_write(A_CTRL, 32'h0000_0001);
    ev_pulse(2'b01, 2'b01, 38'h12_3456_789A, 38'h0, 1'b1);
    // Read starts right after the strobe: level must already be 1 at the ack edge.
    wb_read(A_STATUS, d);
    checks++;
    if (d !== status_exp(1, 0)) begin errors++; $display("FAIL single_level: got %h expected %h", d, status_exp(1, 0)); end
    wb_read(A_TS, d);
    checks++;
    if (d !== 32'h3456_789A) begin errors++; $display("FAIL single_ts_const: got %h expected 3456789a", d); end
    pop_check("single");
    wb_read(A_STATUS, d);
    checks++;
    if (d !== status_exp(0, 0)) begin errors++; $display("FAIL single_after_pop: got %h expected %h", d, status_exp(0, 0)); end
  endtask

  task automatic test_round_robin();
    logic [31:0] d;
    do_reset();
    wb_write(A_CTRL, 32'h0000_0001);
    ev_pulse(2'b11, 2'b10, 38'h01_0000_0011, 38'h02_0000_0022, 1'b1);
    idle(3);
    ev_pulse(2'b01, 2'b01, 38'h03_0000_0033, 38'h0, 1'b1);
    idle(3);
    ev_pulse(2'b11, 2'b11, 38'h04_0000_0044, 38'h05_0000_0055, 1'b1);
    idle(3);
    wb_read(A_STATUS, d);
    checks++;
    if (d !== status_exp(5, 0)) begin errors++; $display("FAIL rr_level: got %h expected %h", d, status_exp(5, 0)); end
    for (int i = 0; i < 5; i++) pop_check("rr");
  endtask

  task automatic test_overflow();
    logic [31:0] d;
`ifdef TDC_EVFIFO_DROPCNT_EN
    exp_drop = 1;
`else
    exp_drop = 0;
`endif
    for (int i = 0; i < 32; i++) begin
      ev_pulse(2'b11, 2'(i), 38'h2A_0000_0000 | 38'(2 * i), 38'h15_0000_0000 | 38'(2 * i + 1), 1'b1);
      idle(2);
    end
    wb_read(A_STATUS, d);
    checks++;
    if (d !== status_exp(64, 0)) begin errors++; $display("FAIL ovf_full: got %h expected %h", d, status_exp(64, 0)); end
    ev_pulse(2'b01, 2'b01, 38'h3F_DEAD_BEEF, 38'h0, 1'b0);
    sb_q.push_back(mk(0, 1'b1, 38'h3F_DEAD_BEEF));
    idle(2);
    ev_pulse(2'b01, 2'b00, 38'h00_BAD0_BAD0, 38'h0, 1'b0);
    idle(2);
    wb_read(A_STATUS, d);
    checks++;
    if (d !== status_exp(64, 1)) begin errors++; $display("FAIL ovf_set: got %h expected %h", d, status_exp(64, 1)); end
    wb_read(A_DROP, d);
    checks++;
    if (d !== 32'(exp_drop)) begin errors++; $display("FAIL ovf_dropcnt: got %h expected %h", d, 32'(exp_drop)); end
    pop_check("ovf_pop1");
    tb_last = 0;
    idle(2);
    wb_read(A_STATUS, d);
    checks++;
    if (d !== status_exp(64, 1)) begin errors++; $display("FAIL ovf_refill: got %h expected %h", d, status_exp(64, 1)); end
    wb_write(A_STATUS, 32'h0004_0000);
    wb_read(A_STATUS, d);
    checks++;
    if (d !== status_exp(64, 0)) begin errors++; $display("FAIL ovf_clear: got %h expected %h", d, status_exp(64, 0)); end
    wb_read(A_DROP, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ovf_dropcnt_clear: got %h expected 0", d); end
    ev_pulse(2'b01, 2'b01, 38'h2B_CAFE_0001, 38'h0, 1'b0);
    sb_q.push_back(mk(0, 1'b1, 38'h2B_CAFE_0001));
    idle(2);
    ev_pulse(2'b01, 2'b01, 38'h00_0BAD_0002, 38'h0, 1'b0);
    idle(2);
    wb_read(A_STATUS, d);
    checks++;
    if (d !== status_exp(64, 1)) begin errors++; $display("FAIL ovf_set2: got %h expected %h", d, status_exp(64, 1)); end
    wb_read(A_DROP, d);
    checks++;
    if (d !== 32'(exp_drop)) begin errors++; $display("FAIL ovf_dropcnt2: got %h expected %h", d, 32'(exp_drop)); end
    while (sb_q.size() > 0) pop_check("ovf_drain");
    tb_last = 0;
    idle(1);
    wb_read(A_STATUS, d);
    checks++;
    if (d !== status_exp(0, 1)) begin errors++; $display("FAIL ovf_drained: got %h expected %h", d, status_exp(0, 1)); end
  endtask

  task automatic test_irq();
    wb_write(A_CTRL, 32'h0000_0401);
    for (int i = 0; i < 3; i++) begin
      ev_pulse(2'b01, 2'b00, 38'h07_0000_0100 + 38'(i), 38'h0, 1'b1);
      idle(2);
    end
    idle(2);
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_below_thr: got %b expected 0", irq_o); end
    ev_pulse(2'b10, 2'b10, 38'h0, 38'h08_0000_0200, 1'b1);
    idle(3);
    checks++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_at_thr: got %b expected 1", irq_o); end
    pop_check("irq");
    idle(2);
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_after_pop: got %b expected 0", irq_o); end
    wb_write(A_CTRL, 32'h0000_0001);
    ev_pulse(2'b01, 2'b01, 38'h09_0000_0300, 38'h0, 1'b1);
    idle(2);
    ev_pulse(2'b10, 2'b00, 38'h0, 38'h0A_0000_0400, 1'b1);
    idle(3);
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_thr0: got %b expected 0", irq_o); end
  endtask

  task automatic test_empty_flush();
    logic [31:0] d;
    logic got;
    // Flush write and a strobe land on the same edge; the strobe must be discarded.
    @(negedge sys_clk);
    wb_adr_i = A_CTRL; wb_dat_i = 32'h0000_0003; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    ev_stb_i = 2'b01; ev_pol_i = 2'b01; ev_ts_i = {38'h0, 38'h11_1111_1111};
    @(posedge sys_clk); #1;
    got = wb_ack_o;
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL flush_ack: got %b expected 1", got); end
    @(negedge sys_clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; ev_stb_i = '0;
    sb_q.delete();
    idle(3);
    wb_read(A_STATUS, d);
    checks++;
    if (d !== status_exp(0, 0)) begin errors++; $display("FAIL flush_status: got %h expected %h", d, status_exp(0, 0)); end
    wb_read(A_DROP, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL flush_dropcnt: got %h expected 0", d); end
    wb_read(A_CTRL, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL flush_ctrl: got %h expected 00000001", d); end
    wb_read(A_META, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL empty_meta: got %h expected 0", d); end
    wb_read(A_STATUS, d);
    checks++;
    if (d !== status_exp(0, 0)) begin errors++; $display("FAIL empty_meta_nopop: got %h expected %h", d, status_exp(0, 0)); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    wb_write(A_CTRL, 32'h0000_0501);
    ev_pulse(2'b11, 2'b01, 38'h01_2345_6789, 38'h02_3456_789A, 1'b1);
    idle(3);
    @(negedge sys_clk);
    wb_adr_i = A_CTRL; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge sys_clk); #1;
    checks++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h0000_0501) begin
      errors++;
      $display("FAIL arst_pre_read: ack=%b dat=%h expected 1 00000501", wb_ack_o, wb_dat_o);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL arst_outputs: ack=%b dat=%h irq=%b expected 0 0 0", wb_ack_o, wb_dat_o, irq_o);
    end
    @(negedge sys_clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    sb_q.delete();
    tb_last = 1;
    wb_read(A_STATUS, d);
    checks++;
    if (d !== status_exp(0, 0)) begin errors++; $display("FAIL arst_status: got %h expected %h", d, status_exp(0, 0)); end
    wb_read(A_CTRL, d);
    checks++;
    if (d !== 32'h0000_0100) begin errors++; $display("FAIL arst_ctrl: got %h expected 00000100", d); end
  endtask

  initial begin
    idle(3);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_irq();
    test_empty_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
